uart_rx_frame_sampler: RTL

Parametrised UART receive engine and successor to the fixed-format start-bit detector. It synchronises the RX line, qualifies the start bit at mid-bit, and samples each bit once at its centre using the programmable clock divisor. Format is runtime-configurable: 5..MAX_DATA_BITS data bits, optional even/odd parity, and 1 or 2 stop bits. It delivers one right-justified word plus error flags per frame to the RX FIFO write port.

---
 rtl/uart_rx_frame_sampler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_sampler.sv
// UART receive engine: synchronised RX line, mid-bit start qualification and
// centre sampling of 5..MAX_DATA_BITS data bits, optional parity, 1 or 2 stop bits.
module uart_rx_frame_sampler #(
  parameter int MAX_DATA_BITS = 9,
  parameter int CD_W          = 13,
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_CD        = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     rxd_i,
  input  logic                     rx_en_i,
  input  logic [CD_W-1:0]          cd_i,
  input  logic [3:0]               data_bits_i,
  input  logic                     parity_en_i,
  input  logic                     parity_odd_i,
  input  logic                     stop2_i,
  input  logic                     fifo_full_i,
  output logic                     fifo_wr_o,
  output logic [MAX_DATA_BITS-1:0] data_o,
  output logic                     parity_err_o,
  output logic                     frame_err_o,
  output logic                     break_o,
  output logic                     overrun_o,
  output logic                     busy_o
);

  localparam int IDX_W = $clog2(MAX_DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  state_t                   state;
  logic [SYNC_STAGES-1:0]   sync;
  logic                     rxs;
  logic                     rxs_prev;
  logic                     fall;
  logic                     en_prev;
  logic [CD_W-1:0]          cd_eff;
  logic [3:0]               nbits_eff;
  logic [CD_W-1:0]          cd_lat;
  logic [3:0]               nbits;
  logic                     par_en;
  logic                     par_odd;
  logic                     two_stop;
  logic [CD_W-1:0]          cnt;
  logic                     tick;
  logic [3:0]               bit_idx;
  logic [MAX_DATA_BITS-1:0] shreg;
  logic                     par_acc;
  logic                     perr;
  logic                     ferr;
  logic                     seen_one;

  assign rxs  = sync[SYNC_STAGES-1];
  // rxs_prev only reads high once the line has been seen idle, so a line
  // held low after a break cannot produce a new start edge.
  assign fall = rxs_prev & ~rxs;
  assign tick = (cnt == CD_W'(1));
  assign busy_o = (state != IDLE);

  always_comb begin
    cd_eff = (cd_i < CD_W'(MIN_CD)) ? CD_W'(MIN_CD) : cd_i;
    nbits_eff = data_bits_i;
    if (data_bits_i < 4'd5) nbits_eff = 4'd5;
    else if (data_bits_i > 4'(MAX_DATA_BITS)) nbits_eff = 4'(MAX_DATA_BITS);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      sync         <= '1;
      rxs_prev     <= 1'b1;
      en_prev      <= 1'b0;
      cd_lat       <= '0;
      nbits        <= '0;
      par_en       <= 1'b0;
      par_odd      <= 1'b0;
      two_stop     <= 1'b0;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      seen_one     <= 1'b0;
      fifo_wr_o    <= 1'b0;
      data_o       <= '0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      break_o      <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], rxd_i};
      rxs_prev  <= rxs;
      en_prev   <= rx_en_i;
      fifo_wr_o <= 1'b0;

      if (fifo_wr_o && fifo_full_i) overrun_o <= 1'b1;
      if (en_prev && !rx_en_i) overrun_o <= 1'b0;

      if (!rx_en_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (fall) begin
              cd_lat   <= cd_eff;
              nbits    <= nbits_eff;
              par_en   <= parity_en_i;
              par_odd  <= parity_odd_i;
              two_stop <= stop2_i;
              cnt      <= cd_eff >> 1;
              state    <= START;
            end
          end
          START: begin
            if (!tick) begin
              cnt <= cnt - CD_W'(1);
            end else if (rxs) begin
              state <= IDLE;
            end else begin
              cnt      <= cd_lat;
              bit_idx  <= '0;
              shreg    <= '0;
              par_acc  <= 1'b0;
              perr     <= 1'b0;
              ferr     <= 1'b0;
              seen_one <= 1'b0;
              state    <= DATA;
            end
          end
          DATA: begin
            if (!tick) begin
              cnt <= cnt - CD_W'(1);
            end else begin
              cnt                      <= cd_lat;
              shreg[bit_idx[IDX_W-1:0]] <= rxs;
              par_acc                  <= par_acc ^ rxs;
              seen_one                 <= seen_one | rxs;
              if (bit_idx == nbits - 4'd1) state <= par_en ? PARITY : STOP1;
              else bit_idx <= bit_idx + 4'd1;
            end
          end
          PARITY: begin
            if (!tick) begin
              cnt <= cnt - CD_W'(1);
            end else begin
              cnt      <= cd_lat;
              perr     <= (rxs != (par_acc ^ par_odd));
              seen_one <= seen_one | rxs;
              state    <= STOP1;
            end
          end
          STOP1, STOP2: begin
            if (!tick) begin
              cnt <= cnt - CD_W'(1);
            end else if (state == STOP1 && two_stop) begin
              cnt      <= cd_lat;
              ferr     <= ~rxs;
              seen_one <= seen_one | rxs;
              state    <= STOP2;
            end else begin
              // Final stop sample: publish the frame and be idle next cycle.
              fifo_wr_o    <= 1'b1;
              data_o       <= shreg;
              parity_err_o <= perr;
              frame_err_o  <= ferr | ~rxs;
              break_o      <= ~(seen_one | rxs);
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
